// File: rtl/wta_disparity_select_v_if.sv
`default_nettype none
// ============================================================================
// Module      : wta_disparity_select_v_if
// Description : Cost-in / disparity-out handshake bundle for the WTA selector.
// Revision    : 1.0 - initial release
// ============================================================================
interface wta_disparity_select_v_if #(
    parameter int DISP_W = 6,
    parameter int COST_W = 16
);
    logic              cost_valid;
    logic              cost_ready;
    logic [COST_W-1:0] matching_cost;
    logic              cost_last;
    logic              disp_valid;
    logic              disp_ready;
    logic [DISP_W-1:0] disparity;
    logic [COST_W-1:0] min_cost;

    modport master (
        output cost_valid, matching_cost, cost_last, disp_ready,
        input  cost_ready, disp_valid, disparity, min_cost
    );

    modport slave (
        input  cost_valid, matching_cost, cost_last, disp_ready,
        output cost_ready, disp_valid, disparity, min_cost
    );
endinterface
`default_nettype wire

// File: rtl/wta_disparity_select_v.sv
`default_nettype none
// ============================================================================
// Module      : wta_disparity_select_v
// Description : Winner-take-all disparity search over MAX_DISP costs per pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module wta_disparity_select_v #(
    parameter int MAX_DISP = 64,
    parameter int DISP_W   = 6,
    parameter int COST_W   = 16
) (
    input  wire logic               clk,
    input  wire logic               rst,
    wta_disparity_select_v_if.slave bus,
    output logic                    seq_error
);

    localparam logic [0:0]        c_ST_ACCUM = 1'b0;
    localparam logic [0:0]        c_ST_HOLD  = 1'b1;
    localparam logic [DISP_W-1:0] c_LAST_D   = DISP_W'(MAX_DISP - 1);

    logic [0:0]        r_state;
    logic [DISP_W-1:0] r_d;
    logic [COST_W-1:0] r_best_cost;
    logic [DISP_W-1:0] r_best_d;
    logic              r_disp_valid;
    logic [DISP_W-1:0] r_disparity;
    logic [COST_W-1:0] r_min_cost;
    logic              r_seq_error;

    logic              w_cost_ready;
    logic              w_accept;
    logic              w_is_last;
    logic              w_take;
    logic [COST_W-1:0] w_new_cost;
    logic [DISP_W-1:0] w_new_d;

    // Ready is forced low during reset so no beat can slip in while rst is held.
    assign w_cost_ready = (r_state == c_ST_ACCUM) && !rst;
    assign w_accept     = bus.cost_valid && w_cost_ready;
    assign w_is_last    = (r_d == c_LAST_D);
    // Strict less-than keeps the lower disparity on ties.
    assign w_take       = (r_d == '0) || (bus.matching_cost < r_best_cost);
    assign w_new_cost   = w_take ? bus.matching_cost : r_best_cost;
    assign w_new_d      = w_take ? r_d : r_best_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_ACCUM;
            r_d          <= '0;
            r_best_cost  <= '0;
            r_best_d     <= '0;
            r_disp_valid <= 1'b0;
            r_disparity  <= '0;
            r_min_cost   <= '0;
            r_seq_error  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_ACCUM: begin
                    if (w_accept) begin
                        r_best_cost <= w_new_cost;
                        r_best_d    <= w_new_d;
                        // Framing errors are only flagged; the internal count stays authoritative.
                        if (bus.cost_last != w_is_last) begin
                            r_seq_error <= 1'b1;
                        end
                        if (w_is_last) begin
                            r_d          <= '0;
                            r_disparity  <= w_new_d;
                            r_min_cost   <= w_new_cost;
                            r_disp_valid <= 1'b1;
                            r_state      <= c_ST_HOLD;
                        end else begin
                            r_d <= r_d + 1'b1;
                        end
                    end
                end
                c_ST_HOLD: begin
                    if (bus.disp_ready) begin
                        r_disp_valid <= 1'b0;
                        r_state      <= c_ST_ACCUM;
                    end
                end
                default: begin
                    r_state <= c_ST_ACCUM;
                end
            endcase
        end
    end

    assign bus.cost_ready = w_cost_ready;
    assign bus.disp_valid = r_disp_valid;
    assign bus.disparity  = r_disparity;
    assign bus.min_cost   = r_min_cost;
    assign seq_error      = r_seq_error;

endmodule
`default_nettype wire

// File: tb/tb_wta_disparity_select_v.sv
`default_nettype none
// ============================================================================
// Module      : tb_wta_disparity_select_v
// Description : Directed self-checking bench for wta_disparity_select_v (4 candidates).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wta_disparity_select_v;

    localparam int MAX_DISP = 4;
    localparam int DISP_W   = 2;
    localparam int COST_W   = 16;

    logic clk;
    logic rst;
    logic seq_error;
    int   total;
    int   bad;

    wta_disparity_select_v_if #(.DISP_W(DISP_W), .COST_W(COST_W)) bus ();

    wta_disparity_select_v #(
        .MAX_DISP (MAX_DISP),
        .DISP_W   (DISP_W),
        .COST_W   (COST_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .seq_error (seq_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one beat at a negedge and hold it until an edge with ready accepts it.
    task automatic send_beat(input logic [15:0] cost, input logic last);
        bit done;
        done = 1'b0;
        bus.cost_valid    = 1'b1;
        bus.matching_cost = cost;
        bus.cost_last     = last;
        for (int n = 0; n < 50 && !done; n++) begin
            if (bus.cost_ready === 1'b1) done = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        if (!done) chk("beat_timeout", 32'd0, 32'd1);
    endtask

    // Send four beats; cost_last on beat index lastpos; gap idle cycles between beats.
    task automatic pixel(input logic [15:0] c0, input logic [15:0] c1,
                         input logic [15:0] c2, input logic [15:0] c3,
                         input int lastpos, input int gap);
        logic [15:0] c [4];
        c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
        for (int i = 0; i < 4; i++) begin
            send_beat(c[i], (i == lastpos));
            bus.cost_valid = 1'b0;
            if (i < 3) begin
                for (int g = 0; g < gap; g++) @(negedge clk);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.cost_valid    = 1'b0;
        bus.matching_cost = '0;
        bus.cost_last     = 1'b0;
        bus.disp_ready    = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_cost_ready", 32'(bus.cost_ready), 32'd0);
        chk("rst_disp_valid", 32'(bus.disp_valid), 32'd0);
        chk("rst_disparity",  32'(bus.disparity),  32'd0);
        chk("rst_min_cost",   32'(bus.min_cost),   32'd0);
        chk("rst_seq_error",  32'(seq_error),      32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(bus.cost_ready), 32'd1);
        @(negedge clk);

        // Basic back-to-back pixel with a tie between d=1 and d=3.
        pixel(16'd10, 16'd5, 16'd7, 16'd5, 3, 0);
        chk("p1_valid",     32'(bus.disp_valid), 32'd1);
        chk("p1_disparity", 32'(bus.disparity),  32'd1);
        chk("p1_min_cost",  32'(bus.min_cost),   32'd5);
        chk("p1_ready_low", 32'(bus.cost_ready), 32'd0);
        @(negedge clk);
        chk("p1_ready_back", 32'(bus.cost_ready), 32'd1);
        chk("p1_valid_drop", 32'(bus.disp_valid), 32'd0);

        // All-max costs: first candidate wins.
        pixel(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3, 0);
        chk("p2_disparity", 32'(bus.disparity), 32'd0);
        chk("p2_min_cost",  32'(bus.min_cost),  32'hFFFF);
        @(negedge clk);

        // Back-pressure: result held 3 cycles while the next beat waits.
        bus.disp_ready = 1'b0;
        pixel(16'd9, 16'd8, 16'd7, 16'd3, 3, 0);
        bus.cost_valid    = 1'b1;
        bus.matching_cost = 16'd20;
        bus.cost_last     = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("p3_valid_hold", 32'(bus.disp_valid), 32'd1);
            chk("p3_disp_hold",  32'(bus.disparity),  32'd3);
            chk("p3_cost_hold",  32'(bus.min_cost),   32'd3);
            chk("p3_ready_low",  32'(bus.cost_ready), 32'd0);
            @(negedge clk);
        end
        bus.disp_ready = 1'b1;
        pixel(16'd20, 16'd5, 16'd30, 16'd40, 3, 0);
        chk("p4_disparity", 32'(bus.disparity), 32'd1);
        chk("p4_min_cost",  32'(bus.min_cost),  32'd5);
        @(negedge clk);

        // Idle gaps between beats do not disturb the search.
        pixel(16'd4, 16'd9, 16'd2, 16'd6, 3, 2);
        chk("p5_disparity", 32'(bus.disparity), 32'd2);
        chk("p5_min_cost",  32'(bus.min_cost),  32'd2);
        chk("p5_seq_clean", 32'(seq_error),     32'd0);
        @(negedge clk);

        // Early cost_last: flag set after beat 2, result still after beat 4.
        send_beat(16'd1, 1'b0);
        send_beat(16'd2, 1'b1);
        bus.cost_valid = 1'b0;
        chk("p6_seq_set",   32'(seq_error),      32'd1);
        chk("p6_no_result", 32'(bus.disp_valid), 32'd0);
        send_beat(16'd3, 1'b0);
        send_beat(16'd4, 1'b1);
        bus.cost_valid = 1'b0;
        chk("p6_valid",     32'(bus.disp_valid), 32'd1);
        chk("p6_disparity", 32'(bus.disparity),  32'd0);
        chk("p6_min_cost",  32'(bus.min_cost),   32'd1);
        @(negedge clk);
        pixel(16'd7, 16'd7, 16'd6, 16'd9, 3, 0);
        chk("p7_disparity", 32'(bus.disparity), 32'd2);
        chk("p7_seq_stick", 32'(seq_error),     32'd1);
        @(negedge clk);

        // Reset mid-pixel discards the partial result and clears the flag.
        send_beat(16'd50, 1'b0);
        send_beat(16'd60, 1'b0);
        bus.cost_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_seq",   32'(seq_error),      32'd0);
        chk("mid_rst_ready", 32'(bus.cost_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pixel(16'd6, 16'd1, 16'd8, 16'd8, 3, 0);
        chk("p8_valid",     32'(bus.disp_valid), 32'd1);
        chk("p8_disparity", 32'(bus.disparity),  32'd1);
        chk("p8_min_cost",  32'(bus.min_cost),   32'd1);
        chk("p8_seq_clean", 32'(seq_error),      32'd0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
